// File: rtl/stepper_pkg.sv
// Shared types, the 8-entry coil pattern table and the phase stepping rule
// used by the stepper phase sequencer.
package stepper_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  // Index 0 is the rightmost entry: 1000,1100,0100,0110,0010,0011,0001,1001.
  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  // Full-step only lands on odd (two-coil) indices; an even phase snaps one
  // position toward the direction of travel.
  function automatic logic [2:0] step_phase(input logic [2:0] phase,
                                            input logic       dir,
                                            input logic       half);
    logic [2:0] delta;
    delta = (half || !phase[0]) ? 3'd1 : 3'd2;
    step_phase = dir ? (phase + delta) : (phase - delta);
  endfunction

endpackage

// File: rtl/stepper_coil_decoder.sv
// Combinational 3-bit phase index to 4-bit coil pattern {A,B,C,D}.
module stepper_coil_decoder
  import stepper_pkg::*;
(
  input  logic [2:0] phase,
  output logic [3:0] pattern
);

  assign pattern = COIL_TABLE[phase];

endmodule

// File: rtl/stepper_phase_sequencer.sv
// Runs commanded step moves on a 4-coil unipolar stepper from an external step tick.
// Optional macro HOLD_RELEASE_EN releases the coils after HOLD_CYCLES idle cycles.
module stepper_phase_sequencer
  import stepper_pkg::*;
#(
  parameter int STEP_W      = 16,
  parameter int POS_W       = 16,
  parameter int HOLD_CYCLES = 5000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step_tick,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              cmd_half,
  input  logic              abort,
  output logic [3:0]        coils,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position
);

  seq_state_e        state_reg, state_next;
  logic [2:0]        phase_reg, phase_next;
  logic [3:0]        coils_reg, coils_next;
  logic [POS_W-1:0]  position_reg, position_next;
  logic [STEP_W-1:0] remaining_reg, remaining_next;
  logic              dir_reg, dir_next;
  logic              half_reg, half_next;
  logic              done_reg, done_next;

  logic              accept;
  logic              hold_expire;
  logic [2:0]        stepped_phase;
  logic [2:0]        decode_phase;
  logic [3:0]        decoded;

  generate
    if (HOLD_CYCLES < 1) begin : g_hold_cycles_invalid
    end
  endgenerate

  assign accept        = cmd_valid && (state_reg == IDLE);
  assign stepped_phase = step_phase(phase_reg, dir_reg, half_reg);
  // In IDLE the decoder serves the accept (energize current phase); in RUN it
  // serves the tick (pattern of the phase being stepped to).
  assign decode_phase  = (state_reg == RUN) ? stepped_phase : phase_reg;

  stepper_coil_decoder u_decoder (
    .phase   (decode_phase),
    .pattern (decoded)
  );

`ifdef HOLD_RELEASE_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  logic [HOLD_W-1:0] idle_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset || accept || (state_reg == RUN)) begin
      idle_cnt_reg <= '0;
    end else if (idle_cnt_reg != HOLD_W'(HOLD_CYCLES)) begin
      idle_cnt_reg <= idle_cnt_reg + HOLD_W'(1);
    end
  end

  assign hold_expire = (state_reg == IDLE) &&
                       (idle_cnt_reg == HOLD_W'(HOLD_CYCLES - 1));
`else
  assign hold_expire = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    coils_next     = coils_reg;
    position_next  = position_reg;
    remaining_next = remaining_reg;
    dir_next       = dir_reg;
    half_next      = half_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          dir_next       = cmd_dir;
          half_next      = cmd_half;
          remaining_next = cmd_steps;
          coils_next     = decoded;
          if (cmd_steps == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end else if (hold_expire) begin
          coils_next = 4'b0000;
        end
      end
      RUN: begin
        // Abort wins over a coincident tick: no step is taken.
        if (abort) begin
          state_next = IDLE;
        end else if (step_tick) begin
          phase_next     = stepped_phase;
          coils_next     = decoded;
          position_next  = dir_reg ? (position_reg + POS_W'(1))
                                   : (position_reg - POS_W'(1));
          remaining_next = remaining_reg - STEP_W'(1);
          if (remaining_reg == STEP_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      phase_reg     <= 3'd0;
      coils_reg     <= 4'b0000;
      position_reg  <= '0;
      remaining_reg <= '0;
      dir_reg       <= 1'b0;
      half_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      coils_reg     <= coils_next;
      position_reg  <= position_next;
      remaining_reg <= remaining_next;
      dir_reg       <= dir_next;
      half_reg      <= half_next;
      done_reg      <= done_next;
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg == RUN);
  assign done      = done_reg;
  assign coils     = coils_reg;
  assign position  = position_reg;

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Randomized and directed checks of stepper_phase_sequencer against a step-level reference model.
module tb_stepper_phase_sequencer;

  logic        clock;
  logic        reset;
  logic        step_tick;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;
  logic        cmd_half;
  logic        abort;
  logic [3:0]  coils;
  logic        busy;
  logic        done;
  logic [15:0] position;

  int errors = 0;
  int checks = 0;

  // Reference model state: phase index, integer position, expected coil drive.
  int         m_phase;
  int         m_pos;
  logic [3:0] m_coils;
  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

  stepper_phase_sequencer #(
    .STEP_W      (16),
    .POS_W       (16),
    .HOLD_CYCLES (20)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .step_tick (step_tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_dir   (cmd_dir),
    .cmd_half  (cmd_half),
    .abort     (abort),
    .coils     (coils),
    .busy      (busy),
    .done      (done),
    .position  (position)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Half mode moves one index; full mode keeps moving until it lands on an odd index.
  function automatic int model_step(input int ph, input bit d, input bit h);
    int p;
    p = ph;
    do begin
      p = d ? (p + 1) % 8 : (p + 7) % 8;
    end while (!h && (p % 2 == 0));
    return p;
  endfunction

  function automatic logic [15:0] pos_exp();
    logic [31:0] v;
    v = m_pos;
    return v[15:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_ready"}, cmd_ready, 1);
    check_eq({tag, "_coils"}, coils, m_coils);
    check_eq({tag, "_pos"}, position, pos_exp());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_phase = 0;
    m_pos   = 0;
    m_coils = 4'b0000;
    check_idle_outputs("reset");
    check_eq("reset_done", done, 0);
  endtask

  // abort_at = k aborts on the tick that would execute step k+1; -1 means no abort.
  task automatic do_move(input int steps, input bit d, input bit h, input int abort_at);
    bit aborted;
    int executed;
    aborted  = 0;
    executed = 0;
    check_eq("pre_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_steps = 16'(steps);
    cmd_dir   = d;
    cmd_half  = h;
    step_tick = 1'($urandom_range(0, 1));
    tick();
    cmd_valid = 1'b0;
    step_tick = 1'b0;
    m_coils = tbl[m_phase];
    check_eq("accept_coils", coils, m_coils);
    check_eq("accept_busy", busy, (steps != 0));
    check_eq("accept_done", done, (steps == 0));
    check_eq("accept_pos", position, pos_exp());
    for (int s = 0; s < steps; s++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        check_eq("gap_busy", busy, 1);
        check_eq("gap_coils", coils, m_coils);
        check_eq("gap_done", done, 0);
      end
      step_tick = 1'b1;
      abort     = (s == abort_at);
      tick();
      step_tick = 1'b0;
      if (abort) begin
        abort   = 1'b0;
        aborted = 1;
        check_idle_outputs("abort");
        check_eq("abort_done", done, 0);
        break;
      end
      m_phase = model_step(m_phase, d, h);
      m_coils = tbl[m_phase];
      m_pos   = d ? m_pos + 1 : m_pos - 1;
      executed++;
      check_eq("step_coils", coils, m_coils);
      check_eq("step_pos", position, pos_exp());
      check_eq("step_busy", busy, (s != steps - 1));
      check_eq("step_done", done, (s == steps - 1));
    end
    tick();
    check_eq("post_done", done, 0);
    check_idle_outputs("post");
    $display("move steps=%0d dir=%0d half=%0d abort_at=%0d executed=%0d aborted=%0d pos=%0d coils=%b",
             steps, d, h, abort_at, executed, aborted, m_pos, m_coils);
  endtask

  initial begin
    reset     = 1'b0;
    step_tick = 1'b0;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir   = 1'b0;
    cmd_half  = 1'b0;
    abort     = 1'b0;
    m_phase   = 0;
    m_pos     = 0;
    m_coils   = 4'b0000;

    do_reset();

    // Half-step forward 5 from phase 0.
    do_move(5, 1'b1, 1'b1, -1);
    check_eq("half_fwd_coils", coils, 4'b0011);
    check_eq("half_fwd_pos", position, 16'd5);

    // Full-step reverse 3 from phase 0: phases 7,5,3.
    do_reset();
    do_move(3, 1'b0, 1'b0, -1);
    check_eq("full_rev_coils", coils, 4'b0110);
    check_eq("full_rev_pos", position, 16'hFFFD);

    // Zero-step command.
    do_move(0, 1'b1, 1'b1, -1);
    check_eq("zero_pos", position, 16'hFFFD);

    // Abort with a coincident tick after 2 of 10 steps.
    do_reset();
    do_move(10, 1'b1, 1'b1, 2);
    check_eq("abort_pos", position, 16'd2);

    // Abort while idle has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("idle_abort");
    check_eq("idle_abort_done", done, 0);

    // Coil hold behaviour after a completed move (one cycle already past done).
    do_move(1, 1'b1, 1'b0, -1);
`ifdef HOLD_RELEASE_EN
    repeat (18) tick();
    check_eq("hold_before_release", coils, m_coils);
    tick();
    check_eq("hold_released", coils, 4'b0000);
    m_coils = 4'b0000;
    do_move(1, 1'b1, 1'b1, -1);
    $display("hold release sequence done, coils=%b", coils);
`else
    repeat (1000) tick();
    check_eq("hold_kept", coils, m_coils);
    $display("hold sequence done, coils=%b", coils);
`endif

    // Randomized moves.
    for (int i = 0; i < 30; i++) begin
      int steps;
      int ab;
      steps = $urandom_range(0, 12);
      ab    = -1;
      if (steps != 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, steps - 1);
      do_move(steps, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
    end

    // Mid-move reset.
    cmd_valid = 1'b1;
    cmd_steps = 16'd10;
    cmd_dir   = 1'b1;
    cmd_half  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    step_tick = 1'b1;
    repeat (3) tick();
    step_tick = 1'b0;
    check_eq("midreset_busy_before", busy, 1);
    do_reset();
    $display("mid-move reset done, pos=%0h coils=%b", position, coils);

    // Position wrap: 32767 half-step forward ticks back to back, then one more.
    cmd_valid = 1'b1;
    cmd_steps = 16'd32767;
    cmd_dir   = 1'b1;
    cmd_half  = 1'b1;
    step_tick = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (32767) tick();
    step_tick = 1'b0;
    m_pos   = 32767;
    m_phase = 7;
    m_coils = tbl[7];
    check_eq("preload_done", done, 1);
    check_eq("preload_pos", position, 16'h7FFF);
    check_eq("preload_coils", coils, 4'b1001);
    tick();
    do_move(1, 1'b1, 1'b1, -1);
    check_eq("wrap_pos", position, 16'h8000);
    check_eq("wrap_coils", coils, 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
